// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM that sequences the multicycle datapath. Every control strobe is
//   decoded from the state being entered and registered, so the outputs always
//   reflect the current state. It also counts retired instructions.
//
//   Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes into a
//   sticky HALT state (halted = 1 until reset). Without it, unknown opcodes
//   retire as NOPs and halted is held at 0.

module multicycle_controller #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [5:0]  OP_RTYPE  = 6'b000000,
  parameter logic [5:0]  OP_LW     = 6'b100011,
  parameter logic [5:0]  OP_SW     = 6'b101011,
  parameter logic [5:0]  OP_BEQ    = 6'b000100,
  parameter logic [5:0]  OP_J      = 6'b000010,
  parameter logic [5:0]  OP_ADDI   = 6'b001000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opCode,
  output logic                 PCWriteCond,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 IRWrite,
  output logic [1:0]           PCSource,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ALUSrcB,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 halted
);

  // State encodings are visible on the debug port, so they are fixed values.
  typedef enum logic [3:0] {
    S_FETCH         = 4'd0,
    S_FETCH_WAIT    = 4'd1,
    S_DECODE        = 4'd2,
    S_MEM_ADDR      = 4'd3,
    S_MEM_READ      = 4'd4,
    S_MEM_READ_WAIT = 4'd5,
    S_MEM_WRITE     = 4'd6,
    S_R_EXEC        = 4'd7,
    S_R_WB          = 4'd8,
    S_BRANCH        = 4'd9,
    S_JUMP          = 4'd10,
    S_ADDI_EXEC     = 4'd11,
    S_ADDI_WB       = 4'd12,
    S_HALT          = 4'd13
  } state_t;

  // Full set of datapath control strobes, registered as one vector.
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 16'h0000;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_DEST = S_HALT;
`else
  localparam state_t ILLEGAL_DEST = S_FETCH;
`endif

  // Control strobes asserted in a given state; anything not listed stays 0.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = CTRL_NONE;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b0;
      end
      S_FETCH_WAIT: begin
        // IR captures the RAM word while the ALU forms PC + 1.
        c.ir_write  = 1'b1;
        c.alu_src_a = 1'b0;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
        c.pc_source = 2'b00;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut for BRANCH.
        c.alu_src_a = 1'b0;
        c.alu_src_b = 2'b11;
        c.alu_op    = 2'b00;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b00;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_READ_WAIT: begin
        // RAM data is valid one cycle after the read address.
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b00;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b00;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b0;
        c.mem_to_reg = 1'b0;
      end
      S_HALT: begin
        c = CTRL_NONE;
      end
      default: begin
        c = CTRL_NONE;
      end
    endcase
    return c;
  endfunction

  state_t                 state_r;
  state_t                 state_next_s;
  ctrl_t                  ctrl_r;
  logic [CNT_WIDTH-1:0]   count_r;
  logic                   halted_r;
  logic                   retire_s;
  logic                   halt_next_s;

  // Next-state selection; opCode only matters in DECODE and MEM_ADDR.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:      state_next_s = S_FETCH_WAIT;
      S_FETCH_WAIT: state_next_s = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_LW:    state_next_s = S_MEM_ADDR;
          OP_SW:    state_next_s = S_MEM_ADDR;
          OP_RTYPE: state_next_s = S_R_EXEC;
          OP_BEQ:   state_next_s = S_BRANCH;
          OP_J:     state_next_s = S_JUMP;
          OP_ADDI:  state_next_s = S_ADDI_EXEC;
          default:  state_next_s = ILLEGAL_DEST;
        endcase
      end
      S_MEM_ADDR: begin
        if (opCode == OP_LW) begin
          state_next_s = S_MEM_READ;
        end else begin
          state_next_s = S_MEM_WRITE;
        end
      end
      S_MEM_READ:      state_next_s = S_MEM_READ_WAIT;
      S_MEM_READ_WAIT: state_next_s = S_FETCH;
      S_MEM_WRITE:     state_next_s = S_FETCH;
      S_R_EXEC:        state_next_s = S_R_WB;
      S_R_WB:          state_next_s = S_FETCH;
      S_BRANCH:        state_next_s = S_FETCH;
      S_JUMP:          state_next_s = S_FETCH;
      S_ADDI_EXEC:     state_next_s = S_ADDI_WB;
      S_ADDI_WB:       state_next_s = S_FETCH;
      S_HALT:          state_next_s = S_HALT;
      // Encodings 14/15 cannot be reached; recover to FETCH if ever seen.
      default:         state_next_s = S_FETCH;
    endcase
  end

  // An instruction retires when the FSM returns to FETCH; a trap never does.
  always_comb begin
    retire_s = 1'b0;
    if ((state_next_s == S_FETCH) && (state_r != S_FETCH)) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
  end

  // Sticky trap flag follows the state being entered.
  always_comb begin
    halt_next_s = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    if (state_next_s == S_HALT) begin
      halt_next_s = 1'b1;
    end else begin
      halt_next_s = 1'b0;
    end
`else
    halt_next_s = 1'b0;
`endif
  end

  // State, registered controls, retire counter and trap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset wins over any in-flight transition: nothing retires or writes.
      state_r  <= S_FETCH;
      ctrl_r   <= ctrl_decode(S_FETCH);
      count_r  <= CNT_ZERO;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      ctrl_r   <= ctrl_decode(state_next_s);
      halted_r <= halt_next_s;
      if (retire_s) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign PCWrite     = ctrl_r.pc_write;
  assign IorD        = ctrl_r.iord;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign IRWrite     = ctrl_r.ir_write;
  assign PCSource    = ctrl_r.pc_source;
  assign ALUOp       = ctrl_r.alu_op;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign RegWrite    = ctrl_r.reg_write;
  assign RegDst      = ctrl_r.reg_dst;
  assign state       = state_r;
  assign instr_count = count_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The reference model is a
// per-opcode list of visited states plus a per-state control table taken from
// the controller's state/strobe definitions; the retire counter is modelled
// as a plain modulo-16 integer (DUT built with CNT_WIDTH = 4 to reach wrap).

module tb_multicycle_controller;

  localparam int W = 4;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef int seq_t[$];

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opCode;
  logic PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic [W-1:0] instr_count;
  logic halted;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_cnt;

  multicycle_controller #(.CNT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .instr_count(instr_count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Expected strobes per state number:
  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcB,ALUSrcA,RegWrite,RegDst}
  function automatic logic [15:0] exp_ctrl(input int s);
    logic pcwc, pcw, iord, mr, mw, m2r, irw, srca, rw, rd;
    logic [1:0] pcs, aop, srcb;
    {pcwc, pcw, iord, mr, mw, m2r, irw, srca, rw, rd} = 10'b0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (s)
      0:  mr = 1'b1;
      1:  begin irw = 1'b1; pcw = 1'b1; srcb = 2'b01; end
      2:  srcb = 2'b11;
      3:  begin srca = 1'b1; srcb = 2'b10; end
      4:  begin mr = 1'b1; iord = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mw = 1'b1; iord = 1'b1; end
      7:  begin srca = 1'b1; aop = 2'b10; end
      8:  begin rw = 1'b1; rd = 1'b1; end
      9:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      10: begin pcw = 1'b1; pcs = 2'b10; end
      11: begin srca = 1'b1; srcb = 2'b10; end
      12: rw = 1'b1;
      default: ;
    endcase
    return {pcwc, pcw, iord, mr, mw, m2r, irw, pcs, aop, srcb, srca, rw, rd};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};
  endfunction

  // States visited from FETCH up to (not including) the return to FETCH.
  function automatic seq_t exp_seq(input logic [5:0] op);
    seq_t q;
    case (op)
      OP_LW:    q = '{0, 1, 2, 3, 4, 5};
      OP_SW:    q = '{0, 1, 2, 3, 6};
      OP_RTYPE: q = '{0, 1, 2, 7, 8};
      OP_BEQ:   q = '{0, 1, 2, 9};
      OP_J:     q = '{0, 1, 2, 10};
      OP_ADDI:  q = '{0, 1, 2, 11, 12};
      default:  q = '{0, 1, 2};
    endcase
    return q;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opCode = OP_J;
    step();
    n_cmp++;
    if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++;
    if (obs_ctrl() !== exp_ctrl(0)) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", obs_ctrl(), exp_ctrl(0)); end
    n_cmp++;
    if (instr_count !== 4'd0 || halted !== 1'b0) begin n_err++; $display("FAIL reset_cnt_halt: got cnt=%0d halted=%b want 0/0", instr_count, halted); end
    step();
    reset = 1'b0;
    exp_cnt = '0;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (state !== 4'(s) || obs_ctrl() !== exp_ctrl(s)) begin
        n_err++; $display("FAIL release_seq: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, obs_ctrl(), s, exp_ctrl(s));
      end
      n_cmp++;
      if (instr_count !== exp_cnt) begin n_err++; $display("FAIL release_cnt: got %0d want %0d", instr_count, exp_cnt); end
      step();
    end
    n_cmp++;
    if (state !== 4'd10 || obs_ctrl() !== exp_ctrl(10)) begin n_err++; $display("FAIL release_jump: got state=%0d ctrl=%h want 10/%h", state, obs_ctrl(), exp_ctrl(10)); end
    step();
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin n_err++; $display("FAIL release_retire: got state=%0d cnt=%0d want 0/%0d", state, instr_count, exp_cnt); end
  endtask

  task automatic test_directed();
    logic [5:0] ops[6];
    seq_t q;
    ops = '{OP_LW, OP_SW, OP_BEQ, OP_J, OP_RTYPE, OP_ADDI};
    foreach (ops[k]) begin
      opCode = ops[k];
      q = exp_seq(ops[k]);
      foreach (q[i]) begin
        n_cmp++;
        if (state !== 4'(q[i]) || obs_ctrl() !== exp_ctrl(q[i])) begin
          n_err++; $display("FAIL directed op=%b: got state=%0d ctrl=%h want state=%0d ctrl=%h", ops[k], state, obs_ctrl(), q[i], exp_ctrl(q[i]));
        end
        n_cmp++;
        if (instr_count !== exp_cnt || halted !== 1'b0) begin
          n_err++; $display("FAIL directed_cnt op=%b: got cnt=%0d halted=%b want %0d/0", ops[k], instr_count, halted, exp_cnt);
        end
        step();
      end
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++;
      if (state !== 4'd0 || instr_count !== exp_cnt) begin
        n_err++; $display("FAIL directed_retire op=%b: got state=%0d cnt=%0d want 0/%0d", ops[k], state, instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_illegal();
    opCode = 6'b111111;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (state !== 4'(s) || obs_ctrl() !== exp_ctrl(s)) begin
        n_err++; $display("FAIL illegal_pre: got state=%0d ctrl=%h want %0d/%h", state, obs_ctrl(), s, exp_ctrl(s));
      end
      step();
    end
`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (state !== 4'd13 || halted !== 1'b1 || obs_ctrl() !== 16'h0000 || instr_count !== exp_cnt) begin
        n_err++; $display("FAIL illegal_halt: got state=%0d halted=%b ctrl=%h cnt=%0d want 13/1/0000/%0d", state, halted, obs_ctrl(), instr_count, exp_cnt);
      end
      opCode = 6'($urandom_range(0, 63));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = '0;
    n_cmp++;
    if (state !== 4'd0 || halted !== 1'b0 || obs_ctrl() !== exp_ctrl(0) || instr_count !== 4'd0) begin
      n_err++; $display("FAIL illegal_unhalt: got state=%0d halted=%b ctrl=%h cnt=%0d want 0/0/%h/0", state, halted, obs_ctrl(), instr_count, exp_ctrl(0));
    end
`else
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++;
    if (state !== 4'd0 || halted !== 1'b0 || instr_count !== exp_cnt) begin
      n_err++; $display("FAIL illegal_nop: got state=%0d halted=%b cnt=%0d want 0/0/%0d", state, halted, instr_count, exp_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    opCode = OP_RTYPE;
    for (int n = 0; n < 16; n++) begin
      repeat (5) step();
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++;
      if (state !== 4'd0 || instr_count !== exp_cnt) begin
        n_err++; $display("FAIL wrap_step %0d: got state=%0d cnt=%0d want 0/%0d", n, state, instr_count, exp_cnt);
      end
    end
    n_cmp++;
    if (instr_count !== 4'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", instr_count); end
    // Abort an R-type in R_EXEC.
    repeat (3) step();
    n_cmp++;
    if (state !== 4'd7) begin n_err++; $display("FAIL abort_setup: got state=%0d want 7", state); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = '0;
    n_cmp++;
    if (state !== 4'd0 || RegWrite !== 1'b0 || instr_count !== 4'd0) begin
      n_err++; $display("FAIL abort_reset: got state=%0d RegWrite=%b cnt=%0d want 0/0/0", state, RegWrite, instr_count);
    end
    step();
    n_cmp++;
    if (state !== 4'd1 || RegWrite !== 1'b0) begin n_err++; $display("FAIL abort_next: got state=%0d RegWrite=%b want 1/0", state, RegWrite); end
    repeat (4) step();
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin n_err++; $display("FAIL abort_rerun: got state=%0d cnt=%0d want 0/%0d", state, instr_count, exp_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] legal[6];
    logic [5:0] op;
    seq_t q;
    int abort_at;
    bit aborted;
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    for (int it = 0; it < 60; it++) begin
`ifdef ILLEGAL_TRAP_EN
      op = legal[$urandom_range(0, 5)];
`else
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom_range(0, 63));
        if (is_legal(op)) op = 6'b111111;
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
`endif
      q = exp_seq(op);
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      aborted = 1'b0;
      foreach (q[i]) begin
        // IR is only loaded at the end of FETCH_WAIT, so opCode is junk before.
        opCode = (i == 0) ? 6'($urandom_range(0, 63)) : op;
        n_cmp++;
        if (state !== 4'(q[i]) || obs_ctrl() !== exp_ctrl(q[i]) || halted !== 1'b0) begin
          n_err++; $display("FAIL random it=%0d op=%b: got state=%0d ctrl=%h halted=%b want %0d/%h/0", it, op, state, obs_ctrl(), halted, q[i], exp_ctrl(q[i]));
        end
        n_cmp++;
        if (instr_count !== exp_cnt) begin n_err++; $display("FAIL random_cnt it=%0d: got %0d want %0d", it, instr_count, exp_cnt); end
        if (i == abort_at) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          exp_cnt = '0;
          aborted = 1'b1;
          break;
        end
        step();
      end
      if (!aborted) exp_cnt = exp_cnt + 4'd1;
      n_cmp++;
      if (state !== 4'd0 || instr_count !== exp_cnt) begin
        n_err++; $display("FAIL random_end it=%0d aborted=%0d: got state=%0d cnt=%0d want 0/%0d", it, aborted, state, instr_count, exp_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    opCode = 6'b000000;
    exp_cnt = '0;
    test_reset();
    test_directed();
    test_illegal();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
